// File: rtl/dmem_pkg.sv
// Shared types and constants for the memory-stage data bus access unit.
// Holds the FSM state encoding, byte-enable constants and the lane-enable helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam logic [3:0]  BE_WORD     = 4'b1111;
  localparam logic [3:0]  BE_NONE     = 4'b0000;
  localparam logic [31:0] FAULT_RDATA = 32'h0;

  function automatic logic [3:0] byteLaneEnable(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/dmem_lane_steer.sv
// Combinational byte-lane steering between the pipeline and the 32-bit data bus.
// Covers store replication, byte-enable generation and zero-extended load byte extraction.
module dmem_lane_steer
  import dmem_pkg::*;
(
  input  logic        i_storeByte,
  input  logic [1:0]  i_storeLane,
  input  logic [31:0] i_storeData,
  output logic [31:0] o_busWData,
  output logic [3:0]  o_busBe,
  input  logic        i_loadByte,
  input  logic [1:0]  i_loadLane,
  input  logic [31:0] i_busRData,
  output logic [31:0] o_loadData
);

  logic [7:0] w_loadByteVal;

  // A byte store drives its byte on every lane; the enables pick the lane that lands.
  always_comb begin
    o_busWData = i_storeData;
    o_busBe    = BE_WORD;
    if (i_storeByte) begin
      o_busWData = {4{i_storeData[7:0]}};
      o_busBe    = byteLaneEnable(i_storeLane);
    end
  end

  always_comb begin
    w_loadByteVal = i_busRData[7:0];
    case (i_loadLane)
      2'd0: w_loadByteVal = i_busRData[7:0];
      2'd1: w_loadByteVal = i_busRData[15:8];
      2'd2: w_loadByteVal = i_busRData[23:16];
      2'd3: w_loadByteVal = i_busRData[31:24];
      default: w_loadByteVal = i_busRData[7:0];
    endcase
    o_loadData = i_loadByte ? {24'b0, w_loadByteVal} : i_busRData;
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Memory-stage access unit: runs one request/ready bus transaction per load/store,
// stalls the pipeline while it is outstanding and aborts with a fault pulse on timeout.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        ByteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemStallM,
  output logic        MemFaultM,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  output logic [3:0]  BusBe,
  input  logic        BusRdy,
  input  logic [31:0] BusRData
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  dmem_state_t       r_state;
  dmem_state_t       w_nextState;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busReq;
  logic              r_busWe;
  logic [31:0]       r_busAddr;
  logic [31:0]       r_busWData;
  logic [3:0]        r_busBe;
  logic [31:0]       r_readData;
  logic              r_fault;
  logic              r_loadByte;
  logic [1:0]        r_loadLane;
  logic              w_access;
  logic              w_timeout;
  logic              w_stall;
  logic [31:0]       w_stWData;
  logic [3:0]        w_stBe;
  logic [31:0]       w_loadData;

  assign w_access  = MemReadM | MemWriteM;
  assign w_timeout = (r_cnt == CNT_LAST);

  dmem_lane_steer u_laneSteer (
    .i_storeByte (ByteM),
    .i_storeLane (ALUOutM[1:0]),
    .i_storeData (WriteDataM),
    .o_busWData  (w_stWData),
    .o_busBe     (w_stBe),
    .i_loadByte  (r_loadByte),
    .i_loadLane  (r_loadLane),
    .i_busRData  (BusRData),
    .o_loadData  (w_loadData)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // DONE never looks at the inputs, so the serviced instruction cannot retrigger.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_access) w_nextState = REQ;
      REQ:     if (BusRdy || w_timeout) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      IDLE:    w_stall = w_access;
      REQ:     w_stall = 1'b1;
      default: w_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_busReq   <= 1'b0;
      r_busWe    <= 1'b0;
      r_busAddr  <= '0;
      r_busWData <= '0;
      r_busBe    <= BE_NONE;
      r_readData <= '0;
      r_fault    <= 1'b0;
      r_loadByte <= 1'b0;
      r_loadLane <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_access) begin
            r_busReq   <= 1'b1;
            r_busWe    <= MemWriteM;
            r_busAddr  <= {ALUOutM[31:2], 2'b00};
            r_busWData <= w_stWData;
            r_busBe    <= w_stBe;
            r_loadByte <= ByteM;
            r_loadLane <= ALUOutM[1:0];
            r_cnt      <= '0;
          end
        end
        REQ: begin
          // A completing handshake takes priority over the final timeout cycle.
          if (BusRdy) begin
            r_busReq   <= 1'b0;
            r_readData <= r_busWe ? 32'h0 : w_loadData;
          end else if (w_timeout) begin
            r_busReq   <= 1'b0;
            r_fault    <= 1'b1;
            r_readData <= FAULT_RDATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_fault <= 1'b0;
          r_busWe <= 1'b0;
          r_busBe <= BE_NONE;
        end
        default: ;
      endcase
    end
  end

  assign MemStallM = w_stall;
  assign MemFaultM = r_fault;
  assign ReadDataM = r_readData;
  assign BusReq    = r_busReq;
  assign BusWe     = r_busWe;
  assign BusAddr   = r_busAddr;
  assign BusWData  = r_busWData;
  assign BusBe     = r_busBe;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: the driver pushes hand-computed expectations,
// a negedge monitor checks bus fields at request start and results at completion.
module tb_dmem_access_unit;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        fault;
    int          stalls;
    int          reqs;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        MemReadM;
  logic        MemWriteM;
  logic        ByteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        MemStallM;
  logic        MemFaultM;
  logic        BusReq;
  logic        BusWe;
  logic [31:0] BusAddr;
  logic [31:0] BusWData;
  logic [3:0]  BusBe;
  logic        BusRdy;
  logic [31:0] BusRData;

  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];

  dmem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ByteM      (ByteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .MemStallM  (MemStallM),
    .MemFaultM  (MemFaultM),
    .BusReq     (BusReq),
    .BusWe      (BusWe),
    .BusAddr    (BusAddr),
    .BusWData   (BusWData),
    .BusBe      (BusBe),
    .BusRdy     (BusRdy),
    .BusRData   (BusRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got event, expected none", name);
  endtask

  // Issue one access and act as the bus slave; waits < 0 means BusRdy never arrives.
  task automatic applyStimulus(input string name, input logic rd, input logic wr, input logic byt,
                               input logic [31:0] addr, input logic [31:0] wdata, input int waits,
                               input logic [31:0] rdata, input logic [31:0] eAddr, input logic [3:0] eBe,
                               input logic [31:0] eWData, input logic [31:0] eRData, input logic eFault);
    exp_t e;
    int   n;
    bit   started;
    bit   finished;
    e.name   = name;
    e.we     = wr;
    e.addr   = eAddr;
    e.be     = eBe;
    e.wdata  = eWData;
    e.rdata  = eRData;
    e.fault  = eFault;
    e.stalls = (waits < 0) ? 5 : waits + 2;
    e.reqs   = (waits < 0) ? 4 : waits + 1;
    expQ.push_back(e);
    MemReadM   = rd;
    MemWriteM  = wr;
    ByteM      = byt;
    ALUOutM    = addr;
    WriteDataM = wdata;
    BusRData   = rdata;
    n        = 0;
    started  = 0;
    finished = 0;
    for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
      @(posedge clk); #1;
      if (BusReq) begin
        started = 1;
        BusRdy  = (waits >= 0 && n == waits);
        n++;
      end else if (started && !MemStallM) begin
        finished = 1;
      end
    end
    BusRdy = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_complete: got no DONE within 40 cycles, expected completion", name);
    end
  endtask

  task automatic idleCycles(input int n);
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    ByteM     = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: bus fields at the first request cycle, results in the DONE cycle.
  initial begin : monitor
    exp_t cur;
    bit   prevStall = 0;
    bit   prevReq   = 0;
    int   stallCnt  = 0;
    int   reqCnt    = 0;
    bit   completing;
    forever begin
      @(negedge clk);
      if (reset) begin
        prevStall = 0;
        prevReq   = 0;
        stallCnt  = 0;
        reqCnt    = 0;
      end else begin
        completing = prevStall && !MemStallM;
        if (BusReq && !prevReq) begin
          if (expQ.size() == 0) failNow("unexpected_req");
          else begin
            cur = expQ[0];
            checkOutput({cur.name, "_we"}, {31'b0, BusWe}, {31'b0, cur.we});
            checkOutput({cur.name, "_addr"}, BusAddr, cur.addr);
            checkOutput({cur.name, "_be"}, {28'b0, BusBe}, {28'b0, cur.be});
            if (cur.we) checkOutput({cur.name, "_wdata"}, BusWData, cur.wdata);
          end
        end
        if (MemStallM) stallCnt++;
        if (BusReq) reqCnt++;
        if (MemFaultM && !completing) failNow("fault_outside_done");
        if (completing) begin
          if (expQ.size() == 0) failNow("unexpected_done");
          else begin
            cur = expQ.pop_front();
            checkOutput({cur.name, "_rdata"}, ReadDataM, cur.rdata);
            checkOutput({cur.name, "_fault"}, {31'b0, MemFaultM}, {31'b0, cur.fault});
            checkOutput({cur.name, "_stalls"}, stallCnt, cur.stalls);
            checkOutput({cur.name, "_reqcycles"}, reqCnt, cur.reqs);
          end
          stallCnt = 0;
          reqCnt   = 0;
        end
        prevStall = MemStallM;
        prevReq   = BusReq;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    reset = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; ByteM = 1'b0;
    ALUOutM = 32'h0; WriteDataM = 32'h0; BusRdy = 1'b0; BusRData = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("rst_busreq", {31'b0, BusReq}, 32'h0);
    checkOutput("rst_buswe", {31'b0, BusWe}, 32'h0);
    checkOutput("rst_fault", {31'b0, MemFaultM}, 32'h0);
    checkOutput("rst_stall", {31'b0, MemStallM}, 32'h0);
    checkOutput("rst_addr", BusAddr, 32'h0);
    checkOutput("rst_wdata", BusWData, 32'h0);
    checkOutput("rst_rdata", ReadDataM, 32'h0);
    checkOutput("rst_be", {28'b0, BusBe}, 32'h0);

    applyStimulus("str_word", 0, 1, 0, 32'h100, 32'hCAFEBABE, 0, 32'h0,
                  32'h100, 4'hF, 32'hCAFEBABE, 32'h0, 0);
    idleCycles(1);
    applyStimulus("ldr_wait3", 1, 0, 0, 32'h104, 32'h0, 3, 32'h12345678,
                  32'h104, 4'hF, 32'h0, 32'h12345678, 0);
    idleCycles(1);
    applyStimulus("ldrb_lane3", 1, 0, 1, 32'h203, 32'h0, 1, 32'hAABBCCDD,
                  32'h200, 4'b1000, 32'h0, 32'h000000AA, 0);
    idleCycles(1);

    BusRdy = 1'b1;
    idleCycles(3);
    BusRdy = 1'b0;
    checkOutput("idle_rdy_busreq", {31'b0, BusReq}, 32'h0);
    checkOutput("idle_rdy_stall", {31'b0, MemStallM}, 32'h0);
    checkOutput("idle_hold_rdata", ReadDataM, 32'h000000AA);

    applyStimulus("strb_lane1", 0, 1, 1, 32'h301, 32'h000000EE, 2, 32'h0,
                  32'h300, 4'b0010, 32'hEEEEEEEE, 32'h0, 0);
    idleCycles(1);
    applyStimulus("ldr_timeout", 1, 0, 0, 32'h500, 32'h0, -1, 32'hDEADBEEF,
                  32'h500, 4'hF, 32'h0, 32'h0, 1);
    idleCycles(2);
    applyStimulus("ldr_misaligned", 1, 0, 0, 32'h60A, 32'h0, 0, 32'h0BADF00D,
                  32'h608, 4'hF, 32'h0, 32'h0BADF00D, 0);
    idleCycles(1);
    applyStimulus("rd_wr_both", 1, 1, 0, 32'h40C, 32'h11223344, 1, 32'hFFFFFFFF,
                  32'h40C, 4'hF, 32'h11223344, 32'h0, 0);
    idleCycles(1);
    applyStimulus("ldrb_lane0", 1, 0, 1, 32'h700, 32'h0, 0, 32'h123456C3,
                  32'h700, 4'b0001, 32'h0, 32'h000000C3, 0);
    idleCycles(1);
    applyStimulus("strb_lane2", 0, 1, 1, 32'h702, 32'h12345678, 0, 32'h0,
                  32'h700, 4'b0100, 32'h78787878, 32'h0, 0);
    idleCycles(1);

    // Reset while a load is waiting on the bus.
    expQ.push_back('{"rst_req", 1'b0, 32'h900, 4'hF, 32'h0, 32'h0, 1'b0, 0, 0});
    MemReadM = 1'b1; ALUOutM = 32'h900; ByteM = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("pre_rst_busreq", {31'b0, BusReq}, 32'h1);
    reset = 1'b1;
    MemReadM = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    expQ.delete();
    checkOutput("mid_rst_busreq", {31'b0, BusReq}, 32'h0);
    checkOutput("mid_rst_fault", {31'b0, MemFaultM}, 32'h0);
    checkOutput("mid_rst_stall", {31'b0, MemStallM}, 32'h0);
    @(posedge clk); #1;
    checkOutput("post_rst_fault", {31'b0, MemFaultM}, 32'h0);

    applyStimulus("b2b_ldr", 1, 0, 0, 32'h800, 32'h0, 0, 32'h55AA55AA,
                  32'h800, 4'hF, 32'h0, 32'h55AA55AA, 0);
    applyStimulus("b2b_str", 0, 1, 0, 32'h804, 32'h0F0F0F0F, 1, 32'h0,
                  32'h804, 4'hF, 32'h0F0F0F0F, 32'h0, 0);
    idleCycles(3);
    checkOutput("queue_drained", expQ.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
